// File: rtl/pad_cfg_serializer_pkg.sv
// pad_cfg_pkg: shared state encoding, default sizes and chain length helper for the pad config serializer.
package pad_cfg_pkg;
  localparam int N_PADS_DEF = 32;
  localparam int CFG_BITS_DEF = 6;
  localparam int CLK_DIV_DEF = 4;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
  function automatic int chain_len(input int n_pads, input int cfg_bits);
    return n_pads * (cfg_bits + 1);
  endfunction
endpackage

// File: rtl/pad_cfg_serializer_if.sv
// pad_cfg_serializer_if: control-register side inputs and pad-ring chain/status outputs of the serializer.
interface pad_cfg_serializer_if
  import pad_cfg_pkg::*;
#(
  parameter int N_PADS = N_PADS_DEF,
  parameter int CFG_BITS = CFG_BITS_DEF
);
  logic [N_PADS-1:0][CFG_BITS-1:0] pad_cfg_i;
  logic [N_PADS-1:0] pad_mux_i;
  logic force_i;
  logic cfg_sclk_o;
  logic cfg_sdata_o;
  logic cfg_latch_o;
  logic busy_o;
  logic done_o;
  modport master (
    output pad_cfg_i, pad_mux_i, force_i,
    input cfg_sclk_o, cfg_sdata_o, cfg_latch_o, busy_o, done_o
  );
  modport slave (
    input pad_cfg_i, pad_mux_i, force_i,
    output cfg_sclk_o, cfg_sdata_o, cfg_latch_o, busy_o, done_o
  );
endinterface

// File: rtl/pad_cfg_serializer_tick_gen.sv
// pad_cfg_tick_gen: CLK_DIV phase counter; phase_end marks the last cycle of a phase, phase_pre the one before it.
module pad_cfg_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic run,
  output logic phase_end,
  output logic phase_pre
);
  localparam int PW = $clog2(CLK_DIV + 1);
  logic [PW-1:0] cnt;
  assign phase_end = cnt == PW'(CLK_DIV - 1);
  assign phase_pre = CLK_DIV > 1 && cnt == PW'(CLK_DIV - 2);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt <= '0;
    else cnt <= (!run || phase_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pad_cfg_serializer.sv
// pad_cfg_serializer: ships {mux,cfg} of every pad to the pad-ring scan chain, MSB pad first, then strobes latch.
module pad_cfg_serializer
  import pad_cfg_pkg::*;
#(
  parameter int N_PADS = N_PADS_DEF,
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input logic HCLK,
  input logic HRESETn,
  pad_cfg_serializer_if.slave bus
);
  localparam int W = CFG_BITS + 1;
  localparam int L = chain_len(N_PADS, CFG_BITS);
  localparam int BW = $clog2(L + 1);
  state_t state;
  logic [L-1:0] word, shadow, sreg;
  logic [BW-1:0] bit_cnt;
  logic pending, phase_end, phase_pre;
  always_comb begin
    word = '0;
    for (int p = 0; p < N_PADS; p++) word[p*W +: W] = {bus.pad_mux_i[p], bus.pad_cfg_i[p]};
  end
  pad_cfg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .run       (state == SHIFT || state == LATCH),
    .phase_end (phase_end),
    .phase_pre (phase_pre)
  );
  // In LOAD the snapshot absorbs any change, so only force_i can re-arm there.
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      pending <= 1'b1;
      shadow <= '0;
      sreg <= '0;
      bit_cnt <= '0;
      bus.cfg_sclk_o <= 1'b0;
      bus.cfg_sdata_o <= 1'b0;
      bus.cfg_latch_o <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
    end else begin
      pending <= bus.force_i || (state != LOAD && (pending || word != shadow));
      bus.done_o <= 1'b0;
      case (state)
        IDLE: if (pending) begin
          state <= LOAD;
          bus.busy_o <= 1'b1;
        end
        LOAD: begin
          state <= SHIFT;
          shadow <= word;
          sreg <= word << 1;
          bit_cnt <= '0;
          bus.cfg_sdata_o <= word[L-1];
        end
        SHIFT: if (phase_end) begin
          bus.cfg_sclk_o <= ~bus.cfg_sclk_o;
          if (bus.cfg_sclk_o) begin
            bit_cnt <= bit_cnt + 1'b1;
            sreg <= sreg << 1;
            bus.cfg_sdata_o <= sreg[L-1];
            if (bit_cnt == BW'(L - 1)) begin
              state <= LATCH;
              bus.cfg_latch_o <= 1'b1;
            end
          end
        end
        LATCH: begin
          // done_o must already be high in the final LATCH cycle, hence the one-cycle lookahead.
          bus.done_o <= bus.cfg_latch_o ? (phase_end && CLK_DIV == 1) : phase_pre;
          if (phase_end) begin
            bus.cfg_latch_o <= 1'b0;
            if (!bus.cfg_latch_o) begin
              state <= IDLE;
              bus.busy_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pad_cfg_serializer.sv
// tb_pad_cfg_serializer: random pad settings against a frame-queue model of what the chain must receive.
module tb_pad_cfg_serializer;
  localparam int N = 2;
  localparam int C = 6;
  localparam int D = 2;
  localparam int L = N * (C + 1);
  localparam int T = 1 + 2 * D * (L + 1);
  localparam int CW = N * C;
  typedef struct packed {
    logic [N-1:0] mux;
    logic [N-1:0][C-1:0] cfg;
  } frame_t;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  frame_t exp_q[$];
  frame_t cur = '0;
  bit rx[$];
  int cyc = 0, t0 = 0, last_done = -100, last_gap = 0, done_cnt = 0, n_frames = 0, lat_w = 0;
  logic [63:0] last_gv = '0;
  logic p_sclk = 1'b0, p_latch = 1'b0, p_busy = 1'b0;
  pad_cfg_serializer_if #(.N_PADS(N), .CFG_BITS(C)) bus ();
  pad_cfg_serializer #(.N_PADS(N), .CFG_BITS(C), .CLK_DIV(D)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  // The chain must see pad N-1 first, each pad as mux then cfg MSB..LSB.
  initial forever begin
    @(negedge HCLK);
    cyc++;
    if (!HRESETn) begin
      rx.delete();
      p_sclk = 1'b0;
      p_latch = 1'b0;
      p_busy = 1'b0;
      lat_w = 0;
    end else begin
      if (bus.cfg_sclk_o && !p_sclk) rx.push_back(bus.cfg_sdata_o);
      if (bus.cfg_sclk_o && p_sclk) check("sdata_hold", bus.cfg_sdata_o, rx[$]);
      if (bus.busy_o && !p_busy) begin
        last_gap = cyc - last_done;
        t0 = cyc;
      end
      if (bus.cfg_latch_o) lat_w++;
      if (bus.cfg_latch_o && !p_latch) begin
        logic [63:0] gv, ev;
        n_frames++;
        gv = '0;
        ev = '0;
        foreach (rx[i]) gv = {gv[62:0], rx[i]};
        last_gv = gv;
        check("sclk_at_latch", bus.cfg_sclk_o, 0);
        check("frame_len", rx.size(), L);
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          frame_t e;
          e = exp_q.pop_front();
          for (int p = N - 1; p >= 0; p--) begin
            ev = {ev[62:0], e.mux[p]};
            for (int b = C - 1; b >= 0; b--) ev = {ev[62:0], e.cfg[p][b]};
          end
          check("frame_data", gv, ev);
        end
        rx.delete();
      end
      if (!bus.cfg_latch_o && p_latch) begin
        check("latch_width", lat_w, D);
        lat_w = 0;
      end
      if (bus.done_o) begin
        done_cnt++;
        last_done = cyc;
        check("xfer_len", cyc - t0 + 1, T);
      end
      p_sclk = bus.cfg_sclk_o;
      p_latch = bus.cfg_latch_o;
      p_busy = bus.busy_o;
    end
  end
  task automatic apply(input logic [N-1:0] m, input logic [N-1:0][C-1:0] c);
    frame_t nf;
    nf.mux = m;
    nf.cfg = c;
    bus.pad_mux_i = m;
    bus.pad_cfg_i = c;
    if (nf != cur) begin
      cur = nf;
      exp_q.push_back(cur);
    end
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < 3000) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    check({tag, "_timeout"}, n < 3000, 1);
    repeat (4) @(posedge HCLK);
    #1;
    check({tag, "_idle"}, {bus.busy_o, bus.cfg_sclk_o, bus.cfg_latch_o}, 0);
  endtask
  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!bus.busy_o && n < 50) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    check({tag, "_busy"}, bus.busy_o, 1);
  endtask
  initial begin
    int first_busy, done_at, d0, act;
    logic [N-1:0][C-1:0] c;
    bus.pad_cfg_i = '0;
    bus.pad_mux_i = '0;
    bus.force_i = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_outputs", {bus.cfg_sclk_o, bus.cfg_sdata_o, bus.cfg_latch_o, bus.busy_o, bus.done_o}, 0);
    exp_q.push_back(cur);
    @(negedge HCLK);
    HRESETn = 1'b1;
    first_busy = 0;
    done_at = 0;
    for (int k = 1; k <= T + 3; k++) begin
      @(posedge HCLK);
      #1;
      if (bus.busy_o && first_busy == 0) first_busy = k;
      if (bus.done_o && done_at == 0) done_at = k;
    end
    check("rst_busy_rise", first_busy, 1);
    check("rst_done_cyc", done_at, T);
    wait_idle("rst_xfer");
    c = '0;
    c[1] = 6'h2A;
    apply(2'b10, c);
    wait_idle("pattern");
    check("pattern_bits", last_gv, 64'h3500);
    for (int i = 0; i < 6; i++) begin
      @(posedge HCLK);
      #1;
      apply(N'($urandom), CW'($urandom));
      wait_idle("rand");
    end
    d0 = done_cnt;
    @(posedge HCLK);
    #1;
    apply(~cur.mux, CW'($urandom));
    wait_busy("mid");
    repeat (20) @(posedge HCLK);
    #1;
    c = cur.cfg;
    c[0] = c[0] ^ C'($urandom_range(1, 63));
    apply(cur.mux, c);
    wait_idle("mid");
    check("mid_dones", done_cnt - d0, 2);
    check("mid_gap", last_gap, 2);
    d0 = done_cnt;
    @(posedge HCLK);
    #1;
    bus.force_i = 1'b1;
    exp_q.push_back(cur);
    @(posedge HCLK);
    #1;
    bus.force_i = 1'b0;
    wait_idle("force");
    check("force_dones", done_cnt - d0, 1);
    act = 0;
    repeat (1000) begin
      @(posedge HCLK);
      #1;
      act += int'(bus.cfg_sclk_o | bus.cfg_latch_o | bus.busy_o);
    end
    check("quiet", act, 0);
    d0 = done_cnt;
    apply(~cur.mux, CW'($urandom));
    wait_busy("load_force");
    bus.force_i = 1'b1;
    exp_q.push_back(cur);
    @(posedge HCLK);
    #1;
    bus.force_i = 1'b0;
    wait_idle("load_force");
    check("load_force_dones", done_cnt - d0, 2);
    @(posedge HCLK);
    #1;
    apply(~cur.mux, CW'($urandom));
    act = 0;
    while (rx.size() < 6 && act < 500) begin
      @(negedge HCLK);
      act++;
    end
    check("bit5_reached", rx.size() >= 6, 1);
    #1;
    HRESETn = 1'b0;
    bus.pad_cfg_i = '0;
    bus.pad_mux_i = '0;
    #1;
    check("async_rst", {bus.cfg_sclk_o, bus.cfg_sdata_o, bus.cfg_latch_o, bus.busy_o, bus.done_o}, 0);
    exp_q.delete();
    cur = '0;
    exp_q.push_back(cur);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    wait_idle("post_rst");
    check("post_rst_bits", last_gv, 0);
    check("done_total", done_cnt, n_frames);
    check("leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end
endmodule
